// File: rtl/ras_ctrl_pkg.sv
// Shared constants for the return-address-stack controller.
// RAS_CTRL_ALT_LINK_EN makes x5 a link register alongside x1.
package ras_ctrl_pkg;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_SWAP = 2'd3
    } ras_op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_UNWIND = 1'b1
    } state_e;

    function automatic logic is_link(input logic [4:0] r);
`ifdef RAS_CTRL_ALT_LINK_EN
        return (r == REG_RA) || (r == REG_T0);
`else
        return (r == REG_RA);
`endif
    endfunction

endpackage

// File: rtl/ras_op_decode.sv
// Instruction word -> RAS hint op (push/pop/swap/none).
// RAS_CTRL_ALT_LINK_EN enables the x5 link and the swap case.
module ras_op_decode
    import ras_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output logic [1:0]  op
);

    logic [6:0] opc;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       is_jal;
    logic       is_jalr;
    logic       lrd;
    logic       lrs;
    logic       same;
    logic       unused_bits;

    assign opc     = inst[6:0];
    assign rd      = inst[11:7];
    assign rs1     = inst[19:15];
    assign is_jal  = (opc == OPC_JAL);
    assign is_jalr = (opc == OPC_JALR);
    assign lrd     = is_link(rd);
    assign lrs     = is_link(rs1);
    assign same    = (rd == rs1);

    assign unused_bits = ^{inst[31:20], inst[14:12]};

    // Link-register hint table; the arms are mutually exclusive.
    always_comb begin
        op = OP_NONE;
        unique case (1'b1)
            is_jal & lrd:                  op = OP_PUSH;
            is_jalr & lrd & !lrs:          op = OP_PUSH;
            is_jalr & !lrd & lrs:          op = OP_POP;
            is_jalr & lrd & lrs & same:    op = OP_PUSH;
`ifdef RAS_CTRL_ALT_LINK_EN
            is_jalr & lrd & lrs & !same:   op = OP_SWAP;
`endif
            default:                       op = OP_NONE;
        endcase
    end

endmodule

// File: rtl/ras_ctrl.sv
// Fetch-side RAS controller: issues push/pop, tracks speculative ops,
// and unwinds them youngest-first on flush (RAS_CTRL_ALT_LINK_EN: x5 link).
module ras_ctrl
    import ras_ctrl_pkg::*;
#(
    parameter int TRACK_ADDR_WIDTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_inst,
    input  logic        commit_ras,
    input  logic        flush,
    output logic        push,
    output logic        pop,
    output logic        rollback_push,
    output logic        rollback_pop,
    output logic        busy,
    output logic        track_full
);

    localparam int AW = TRACK_ADDR_WIDTH;
    localparam int CW = TRACK_ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << TRACK_ADDR_WIDTH;

    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [1:0]    trk [DEPTH];
    logic [AW-1:0] head;
    logic [CW-1:0] count;
    state_e        state;
    logic          last_q;

    logic [1:0]    dec_op;
    logic          issue;
    logic          commit_ok;
    logic [CW-1:0] cnt_after;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;
    logic [1:0]    top_op;

    ras_op_decode u_dec (
        .inst (fetch_inst),
        .op   (dec_op)
    );

    assign busy       = (state == ST_UNWIND) | last_q;
    assign track_full = (count == CNT_FULL);

    assign issue = fetch_valid & !busy & !track_full & !flush
                 & (dec_op != OP_NONE);

    assign push = issue & ((dec_op == OP_PUSH) | (dec_op == OP_SWAP));
    assign pop  = issue & ((dec_op == OP_POP)  | (dec_op == OP_SWAP));

    assign commit_ok = commit_ras & (count != '0) & (state == ST_IDLE);
    assign cnt_after = count - (commit_ok ? CNT_ONE : '0);

    assign wr_idx  = head + count[AW-1:0];
    assign top_idx = head + count[AW-1:0] - IDX_ONE;
    assign top_op  = trk[top_idx];

    // Record each issued op at the tail of the tracker.
    always_ff @(posedge clk) begin
        if (issue) begin
            trk[wr_idx] <= dec_op;
        end
    end

    // Pointer bookkeeping, flush FSM and registered rollback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            head          <= '0;
            count         <= '0;
            last_q        <= 1'b0;
            rollback_push <= 1'b0;
            rollback_pop  <= 1'b0;
        end else begin
            rollback_push <= 1'b0;
            rollback_pop  <= 1'b0;
            last_q        <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    head  <= head + (commit_ok ? IDX_ONE : '0);
                    count <= cnt_after + (issue ? CNT_ONE : '0);
                    if (flush && (cnt_after != '0)) begin
                        state <= ST_UNWIND;
                    end
                end
                ST_UNWIND: begin
                    unique case (top_op)
                        OP_PUSH: rollback_pop  <= 1'b1;
                        OP_POP:  rollback_push <= 1'b1;
`ifdef RAS_CTRL_ALT_LINK_EN
                        // Swap left the pointer alone; nothing to undo.
                        OP_SWAP: rollback_push <= 1'b0;
`endif
                        default: rollback_pop  <= 1'b0;
                    endcase
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state  <= ST_IDLE;
                        last_q <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl.
// Output vector: {push, pop, rollback_push, rollback_pop, busy, track_full}.
module tb_ras_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic        commit_ras;
    logic        flush;
    logic        push;
    logic        pop;
    logic        rollback_push;
    logic        rollback_pop;
    logic        busy;
    logic        track_full;

    localparam logic [31:0] JAL1 = 32'h000000EF;
    localparam logic [31:0] RET  = 32'h00008067;
    localparam logic [31:0] SWP  = 32'h000280E7;

    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] exp_q[$];

    ras_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_inst    (fetch_inst),
        .commit_ras    (commit_ras),
        .flush         (flush),
        .push          (push),
        .pop           (pop),
        .rollback_push (rollback_push),
        .rollback_pop  (rollback_pop),
        .busy          (busy),
        .track_full    (track_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic r, input logic fv,
                       input logic [31:0] inst, input logic cm,
                       input logic fl, input logic [5:0] e);
        logic [5:0] got;
        rst         = r;
        fetch_valid = fv;
        fetch_inst  = inst;
        commit_ras  = cm;
        flush       = fl;
        exp_q.push_back(e);
        @(negedge clk);
        got = {push, pop, rollback_push, rollback_pop, busy, track_full};
        check(tag, {2'b00, got}, {2'b00, exp_q.pop_front()});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [5:0] e);
        cyc(tag, 1'b0, 1'b0, 32'h13, 1'b0, 1'b0, e);
    endtask

    task automatic fetch(input string tag, input logic [31:0] inst,
                         input logic [5:0] e);
        cyc(tag, 1'b0, 1'b1, inst, 1'b0, 1'b0, e);
    endtask

    task automatic chk_cnt(input string tag, input int n);
        check(tag, {4'b0, dut.count}, 8'(n));
    endtask

    initial begin
        rst = 1'b1; fetch_valid = 1'b0; fetch_inst = 32'h13;
        commit_ras = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 1'b1, 1'b0, 32'h13, 1'b0, 1'b0, 6'b000000);
        chk_cnt("reset_cnt", 0);

        // call then return, then unwind both
        fetch("jal_push", JAL1, 6'b100000);
        chk_cnt("cnt1", 1);
        fetch("ret_pop", RET, 6'b010000);
        chk_cnt("cnt2", 2);
        idle("no_rb", 6'b000000);
        cyc("fl_pp", 1'b0, 1'b0, 32'h13, 1'b0, 1'b1, 6'b000000);
        idle("pp_u1", 6'b000010);
        idle("pp_rbpush", 6'b001010);
        idle("pp_rbpop", 6'b000110);
        idle("pp_done", 6'b000000);
        chk_cnt("pp_cnt", 0);

        // three calls, one commit, flush
        cyc("rst2", 1'b1, 1'b0, 32'h13, 1'b0, 1'b0, 6'b000000);
        for (int i = 0; i < 3; i++) fetch("call3", JAL1, 6'b100000);
        cyc("commit", 1'b0, 1'b0, 32'h13, 1'b1, 1'b0, 6'b000000);
        chk_cnt("cnt_commit", 2);
        cyc("flush3", 1'b0, 1'b0, 32'h13, 1'b0, 1'b1, 6'b000000);
        idle("c3_u1", 6'b000010);
        idle("c3_rb1", 6'b000110);
        idle("c3_rb2", 6'b000110);
        idle("c3_done", 6'b000000);
        chk_cnt("c3_cnt", 0);

        // fill, overflow attempt, commit, wrap, full unwind
        cyc("rst3", 1'b1, 1'b0, 32'h13, 1'b0, 1'b0, 6'b000000);
        for (int i = 0; i < 8; i++) fetch("fill", JAL1, 6'b100000);
        fetch("full_blk", JAL1, 6'b000001);
        cyc("full_cm", 1'b0, 1'b0, 32'h13, 1'b1, 1'b0, 6'b000001);
        fetch("wrap_push", JAL1, 6'b100000);
        idle("full_again", 6'b000001);
        cyc("flush8", 1'b0, 1'b0, 32'h13, 1'b0, 1'b1, 6'b000001);
        idle("u8_first", 6'b000011);
        for (int i = 0; i < 7; i++) idle("u8_rb", 6'b000110);
        idle("u8_last", 6'b000110);
        idle("u8_done", 6'b000000);
        chk_cnt("u8_cnt", 0);

        // flush with empty tracker
        cyc("fl_empty", 1'b0, 1'b0, 32'h13, 1'b0, 1'b1, 6'b000000);
        idle("empty_idle", 6'b000000);

        // jalr x1,0(x5)
        cyc("rst4", 1'b1, 1'b0, 32'h13, 1'b0, 1'b0, 6'b000000);
`ifdef RAS_CTRL_ALT_LINK_EN
        fetch("swap", SWP, 6'b110000);
        cyc("fl_swap", 1'b0, 1'b0, 32'h13, 1'b0, 1'b1, 6'b000000);
        idle("sw_u1", 6'b000010);
        idle("sw_last", 6'b000010);
`else
        fetch("swap", SWP, 6'b100000);
        cyc("fl_swap", 1'b0, 1'b0, 32'h13, 1'b0, 1'b1, 6'b000000);
        idle("sw_u1", 6'b000010);
        idle("sw_last", 6'b000110);
`endif
        idle("sw_done", 6'b000000);

        // inputs ignored while unwinding 4 entries
        for (int i = 0; i < 4; i++) fetch("call4", JAL1, 6'b100000);
        cyc("flush4", 1'b0, 1'b0, 32'h13, 1'b0, 1'b1, 6'b000000);
        cyc("ig_u1", 1'b0, 1'b1, JAL1, 1'b1, 1'b1, 6'b000010);
        for (int i = 0; i < 3; i++)
            cyc("ig_rb", 1'b0, 1'b1, JAL1, 1'b1, 1'b1, 6'b000110);
        cyc("ig_last", 1'b0, 1'b1, JAL1, 1'b1, 1'b1, 6'b000110);
        idle("ig_done", 6'b000000);
        chk_cnt("ig_cnt", 0);

        // reset on second unwind cycle
        for (int i = 0; i < 3; i++) fetch("call_r", JAL1, 6'b100000);
        cyc("flush_r", 1'b0, 1'b0, 32'h13, 1'b0, 1'b1, 6'b000000);
        idle("r_u1", 6'b000010);
        cyc("r_u2rst", 1'b1, 1'b0, 32'h13, 1'b0, 1'b0, 6'b000110);
        idle("r_after", 6'b000000);
        chk_cnt("r_cnt", 0);
        fetch("r_push", JAL1, 6'b100000);
        chk_cnt("r_cnt1", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
Fetch-side controller for the return-address stack. It decodes each fetched instruction into RAS push/pop requests per the RISC-V link-register hint rules and drives them to the RAS in the same cycle. It tracks every speculative RAS operation that has not yet committed in a small LIFO. On a branch mispredict flush, it walks that LIFO youngest-first and emits one rollback per cycle, restoring the RAS pointer.

Parameters:
TRACK_ADDR_WIDTH, 3, log2 of tracker depth; TRACK_DEPTH = 1 << TRACK_ADDR_WIDTH = 8 entries

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
fetch_valid  in  1  fetch_inst valid this cycle
fetch_inst  in  32  fetched instruction word
commit_ras  in  1  oldest tracked RAS op has retired; dequeue it
flush  in  1  mispredict; squash all uncommitted tracked ops
push  out  1  RAS push (combinational)
pop  out  1  RAS pop (combinational)
rollback_push  out  1  undo a pop: pointer +1 (registered)
rollback_pop  out  1  undo a push: pointer -1 (registered)
busy  out  1  unwinding in progress; fetch must stall
track_full  out  1  tracker holds TRACK_DEPTH entries

Behaviour:
- Reset (rst=1 at posedge): state IDLE, count=0, rollback_push=0, rollback_pop=0. With fetch_valid=0, push, pop, busy and track_full are all 0.
- Decode: link(r) = (r==x1) or (r==x5).
  - JAL (opcode 1101111): push if link(rd).
  - JALR (opcode 1100111):
    - link(rd) & !link(rs1): push
    - !link(rd) & link(rs1): pop
    - link(rd) & link(rs1) & rd==rs1: push
    - link(rd) & link(rs1) & rd!=rs1: push+pop (SWAP)
  - All other instructions: no op.
- Issue gate: op issued only when fetch_valid & !busy & !track_full & !flush. Otherwise push=pop=0 and nothing is recorded.
- Record: each issued op is written to the tracker at index count, same edge; count+1. Entry encoding is 2 bits: OP_PUSH, OP_POP, OP_SWAP.
- Commit: commit_ras & count>0 removes the oldest entry (head pointer advance, count-1). commit_ras with count==0 is ignored. Commit and record in the same cycle: count unchanged.
- FSM IDLE -> UNWIND on flush when count (after same-cycle commit) > 0. If that count is 0, stay IDLE.
- Flush and commit in the same cycle: commit is applied first, then the remaining entries are unwound.
- UNWIND, one entry per cycle, youngest first. The registered output asserts the cycle after the entry is taken:
  - OP_PUSH -> rollback_pop=1
  - OP_POP -> rollback_push=1
  - OP_SWAP -> neither output; the cycle is still consumed. The pointer was unchanged by SWAP; the overwritten data is not recoverable.
- UNWIND -> IDLE when the last entry is taken. busy=1 for the whole UNWIND state plus the final rollback output cycle.
- Latency: flush with N entries -> rollbacks on cycles +1..+N; busy falls at cycle +N+1.
- flush or commit_ras during UNWIND: ignored.
- Tracker is circular; head and tail wrap modulo TRACK_DEPTH. Count is TRACK_ADDR_WIDTH+1 bits wide.
- Rollback outputs are never asserted together, and never in the same cycle as push/pop.
- rst during UNWIND: immediate return to IDLE, count=0, rollback outputs 0 next cycle.

Optional Feature:
RAS_CTRL_ALT_LINK_EN
- Defined: x5 is treated as a link register, as in Decode above.
- Undefined: link(r) = (r==x1) only. The SWAP case then cannot arise, and OP_SWAP handling is compiled out.

Decomposition:
- Shared package/define file: opcode constants OPC_JAL and OPC_JALR; link register indices; op encodings OP_NONE/OP_PUSH/OP_POP/OP_SWAP; FSM state encodings ST_IDLE/ST_UNWIND.
- One sub-module, ras_op_decode: purely combinational, fetch_inst -> 2-bit op.
- Tracker storage, pointers and FSM stay in ras_ctrl.

Test Plan:
- JAL x1 fetched, then JALR x0,0(x1) -> push=1 in cycle 1, pop=1 in cycle 2; count 1 then 2; no rollback.
- Three JAL x1 calls, commit_ras once, then flush -> rollback_pop on 2 consecutive cycles; busy high 3 cycles; count=0 after.
- Eight JAL x1 calls without commit -> track_full=1; a 9th JAL gives push=0; commit_ras -> track_full=0, and the next JAL pushes.
- JALR x1,0(x5) with RAS_CTRL_ALT_LINK_EN defined -> push=pop=1 in one cycle; flush -> no rollback output, busy 2 cycles. With the macro undefined, the same instruction gives push only, and flush gives rollback_pop.
- During UNWIND of 4 entries: fetch JAL x1, commit_ras and flush all ignored -> exactly 4 rollbacks, no push.
- rst asserted on the 2nd UNWIND cycle -> next cycle busy=0, rollbacks 0, count=0; a subsequent JAL x1 pushes normally.
